// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: m0 (CPU) and m1 (loader) share one synchronous-read
// memory. Ownership is bounded to BURST_MAX beats whenever the other port is waiting.
module mem_arbiter #(
   parameter int WORD_SIZE = 32,
   parameter int ADDR_LEN  = 5,
   parameter int BURST_MAX = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 m0_req,
   input  logic                 m0_we,
   input  logic [ADDR_LEN-1:0]  m0_addr,
   input  logic [WORD_SIZE-1:0] m0_wdata,
   input  logic                 m1_req,
   input  logic                 m1_we,
   input  logic [ADDR_LEN-1:0]  m1_addr,
   input  logic [WORD_SIZE-1:0] m1_wdata,
   output logic                 m0_gnt,
   output logic                 m1_gnt,
   output logic                 m0_rvalid,
   output logic                 m1_rvalid,
   output logic [WORD_SIZE-1:0] rdata,
   output logic                 mem_en,
   output logic                 mem_we,
   output logic [ADDR_LEN-1:0]  mem_addr,
   output logic [WORD_SIZE-1:0] mem_wdata,
   input  logic [WORD_SIZE-1:0] mem_rdata,
   output logic                 busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_e;

   localparam logic [3:0] CNT_LAST = 4'(BURST_MAX - 1);

   state_e     state_q;
   logic       prio_q;
   logic [3:0] cnt_q;
   logic       m0_rvalid_q, m0_rvalid_d;
   logic       m1_rvalid_q, m1_rvalid_d;
   logic       acc0, acc1;
   logic       cnt_last;

   // A beat is accepted whenever the owner keeps its request high.
   always_comb begin
      acc0        = (state_q == OWN0) && m0_req;
      acc1        = (state_q == OWN1) && m1_req;
      cnt_last    = (cnt_q == CNT_LAST);
      m0_rvalid_d = acc0 && !m0_we;
      m1_rvalid_d = acc1 && !m1_we;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         prio_q      <= 1'b0;
         cnt_q       <= 4'd0;
         m0_rvalid_q <= 1'b0;
         m1_rvalid_q <= 1'b0;
      end else begin
         m0_rvalid_q <= m0_rvalid_d;
         m1_rvalid_q <= m1_rvalid_d;
         case (state_q)
            IDLE: begin
               cnt_q <= 4'd0;
               if (m0_req && (!m1_req || !prio_q)) begin
                  state_q <= OWN0;
               end else if (m1_req) begin
                  state_q <= OWN1;
               end
            end
            OWN0: begin
               if (!m0_req) begin
                  state_q <= IDLE;
                  cnt_q   <= 4'd0;
                  prio_q  <= 1'b1;
               end else if (cnt_last && m1_req) begin
                  // Burst exhausted with m1 waiting: hand over without a bubble.
                  state_q <= OWN1;
                  cnt_q   <= 4'd0;
                  prio_q  <= 1'b0;
               end else if (!cnt_last) begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            OWN1: begin
               if (!m1_req) begin
                  state_q <= IDLE;
                  cnt_q   <= 4'd0;
                  prio_q  <= 1'b0;
               end else if (cnt_last && m0_req) begin
                  state_q <= OWN0;
                  cnt_q   <= 4'd0;
                  prio_q  <= 1'b1;
               end else if (!cnt_last) begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= 4'd0;
            end
         endcase
      end
   end

   // NOTE: outputs are masked by rst so they read zero throughout reset, including
   // a pending rvalid and the grant of a state register not yet cleared.
   always_comb begin
      m0_gnt    = !rst && acc0;
      m1_gnt    = !rst && acc1;
      m0_rvalid = !rst && m0_rvalid_q;
      m1_rvalid = !rst && m1_rvalid_q;
      busy      = !rst && (state_q != IDLE);
      mem_en    = m0_gnt || m1_gnt;
      mem_we    = (m0_gnt && m0_we) || (m1_gnt && m1_we);
      mem_addr  = '0;
      mem_wdata = '0;
      if (m0_gnt) begin
         mem_addr  = m0_addr;
         mem_wdata = m0_wdata;
      end else if (m1_gnt) begin
         mem_addr  = m1_addr;
         mem_wdata = m1_wdata;
      end
      rdata = mem_rdata;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 32-word synchronous-read memory model;
// expected values are hand-derived per cycle from the arbitration rules.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [4:0]  m0_addr, m1_addr;
   logic [31:0] m0_wdata, m1_wdata;
   logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
   logic [31:0] rdata;
   logic        mem_en, mem_we;
   logic [4:0]  mem_addr;
   logic [31:0] mem_wdata, mem_rdata;
   logic        busy;

   logic [31:0] mem [32];
   int          n_checks = 0;
   int          n_fail   = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.WORD_SIZE(32), .ADDR_LEN(5), .BURST_MAX(4)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
      .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
   );

   // Synchronous-read memory: data appears one cycle after a read strobe.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata     <= mem[mem_addr];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #1;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_gnt0"},  32'(m0_gnt),    32'd0);
      check({tag, "_gnt1"},  32'(m1_gnt),    32'd0);
      check({tag, "_en"},    32'(mem_en),    32'd0);
      check({tag, "_we"},    32'(mem_we),    32'd0);
      check({tag, "_addr"},  32'(mem_addr),  32'd0);
      check({tag, "_wdata"}, mem_wdata,      32'd0);
      check({tag, "_busy"},  32'(busy),      32'd0);
      check({tag, "_rv0"},   32'(m0_rvalid), 32'd0);
      check({tag, "_rv1"},   32'(m1_rvalid), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 + 32'(i);
      mem_rdata = '0;
      rst = 1'b1;
      m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
      m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
      repeat (3) next_cycle();
      m0_req = 1'b1; m1_req = 1'b1;
      settle();
      check_quiet("reset");
      next_cycle();
      rst = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
      settle();
      check("post_reset_busy", 32'(busy), 32'd0);

      // Single read of address 5 by m0
      next_cycle();
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 5'd5;
      settle();
      check("rd_bubble_gnt0", 32'(m0_gnt), 32'd0);
      check("rd_bubble_busy", 32'(busy),   32'd0);
      next_cycle();
      check("rd_gnt0",  32'(m0_gnt),   32'd1);
      check("rd_gnt1",  32'(m1_gnt),   32'd0);
      check("rd_en",    32'(mem_en),   32'd1);
      check("rd_we",    32'(mem_we),   32'd0);
      check("rd_addr",  32'(mem_addr), 32'd5);
      check("rd_busy",  32'(busy),     32'd1);
      next_cycle();
      m0_req = 1'b0;
      settle();
      check("rd_rv0",   32'(m0_rvalid), 32'd1);
      check("rd_rv1",   32'(m1_rvalid), 32'd0);
      check("rd_data",  rdata,          32'hA000_0005);
      check("rd_drop_gnt0", 32'(m0_gnt),   32'd0);
      check("rd_drop_addr", 32'(mem_addr), 32'd0);
      check("rd_drop_busy", 32'(busy),     32'd1);
      next_cycle();
      check("rd_done_busy", 32'(busy),      32'd0);
      check("rd_done_rv0",  32'(m0_rvalid), 32'd0);

      // Reset, then both ports stream reads together: 4 x m0, 4 x m1, 4 x m0
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      for (int c = 0; c <= 12; c++) begin
         logic g0, g1, rv0, rv1;
         next_cycle();
         m0_req = 1'b1; m1_req = 1'b1; m0_we = 1'b0; m1_we = 1'b0;
         m0_addr = 5'(c); m1_addr = 5'(c + 16);
         settle();
         g0  = (c >= 1 && c <= 4) || (c >= 9 && c <= 12);
         g1  = (c >= 5 && c <= 8);
         rv0 = (c >= 2 && c <= 5) || (c >= 10);
         rv1 = (c >= 6 && c <= 9);
         check($sformatf("fair_gnt0_c%0d", c), 32'(m0_gnt),    32'(g0));
         check($sformatf("fair_gnt1_c%0d", c), 32'(m1_gnt),    32'(g1));
         check($sformatf("fair_rv0_c%0d", c),  32'(m0_rvalid), 32'(rv0));
         check($sformatf("fair_rv1_c%0d", c),  32'(m1_rvalid), 32'(rv1));
         if (g0) check($sformatf("fair_addr_c%0d", c), 32'(mem_addr), 32'(c));
         if (g1) check($sformatf("fair_addr_c%0d", c), 32'(mem_addr), 32'(c + 16));
         if (rv0) check($sformatf("fair_data_c%0d", c), rdata, 32'hA000_0000 + 32'(c - 1));
         if (rv1) check($sformatf("fair_data_c%0d", c), rdata, 32'hA000_0000 + 32'(c + 15));
      end
      next_cycle();
      m0_req = 1'b0; m1_req = 1'b0;
      settle();
      check("fair_tail_rv0",  32'(m0_rvalid), 32'd1);
      check("fair_tail_data", rdata,          32'hA000_000C);
      check("fair_tail_gnt1", 32'(m1_gnt),    32'd0);
      check("fair_tail_busy", 32'(busy),      32'd1);
      next_cycle();
      check("fair_end_busy", 32'(busy), 32'd0);

      // m1 writes the highest address, then reads it back
      next_cycle();
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 5'd31; m1_wdata = 32'hDEAD_BEEF;
      settle();
      check("wr_bubble_gnt1", 32'(m1_gnt), 32'd0);
      next_cycle();
      check("wr_gnt1",  32'(m1_gnt),   32'd1);
      check("wr_we",    32'(mem_we),   32'd1);
      check("wr_addr",  32'(mem_addr), 32'd31);
      check("wr_wdata", mem_wdata,     32'hDEAD_BEEF);
      next_cycle();
      m1_we = 1'b0; m1_wdata = '0;
      settle();
      check("wr_no_rv1", 32'(m1_rvalid), 32'd0);
      check("rb_gnt1",   32'(m1_gnt),    32'd1);
      check("rb_we",     32'(mem_we),    32'd0);
      next_cycle();
      m1_req = 1'b0;
      settle();
      check("rb_rv1",  32'(m1_rvalid), 32'd1);
      check("rb_rv0",  32'(m0_rvalid), 32'd0);
      check("rb_data", rdata,          32'hDEAD_BEEF);
      next_cycle();
      check("rb_end_busy", 32'(busy), 32'd0);

      // m1 streams 20 reads alone: no bubble, counter saturates at 3
      next_cycle();
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 5'd0;
      settle();
      check("solo_bubble_gnt1", 32'(m1_gnt), 32'd0);
      for (int b = 0; b < 20; b++) begin
         next_cycle();
         m1_addr = 5'(b);
         settle();
         check($sformatf("solo_gnt1_b%0d", b), 32'(m1_gnt),    32'd1);
         check($sformatf("solo_gnt0_b%0d", b), 32'(m0_gnt),    32'd0);
         check($sformatf("solo_cnt_b%0d", b),  32'(dut.cnt_q), (b < 3) ? 32'(b) : 32'd3);
         check($sformatf("solo_rv1_b%0d", b),  32'(m1_rvalid), (b >= 1) ? 32'd1 : 32'd0);
      end
      next_cycle();
      m1_req = 1'b0;
      settle();
      check("solo_tail_rv1", 32'(m1_rvalid), 32'd1);
      next_cycle();
      check("solo_end_busy", 32'(busy), 32'd0);

      // Complete one m0 read so prio points at m1, then reset mid-read
      next_cycle();
      m0_req = 1'b1; m0_addr = 5'd7;
      next_cycle();
      next_cycle();
      m0_req = 1'b0;
      settle();
      check("pre_rst_data", rdata, 32'hA000_0007);
      next_cycle();
      check("pre_rst_prio", 32'(dut.prio_q), 32'd1);
      m0_req = 1'b1; m0_addr = 5'd9;
      next_cycle();
      check("mid_gnt0", 32'(m0_gnt), 32'd1);
      next_cycle();
      rst = 1'b1; m0_req = 1'b1; m1_req = 1'b1;
      settle();
      check_quiet("mid_rst");
      next_cycle();
      rst = 1'b0;
      settle();
      check_quiet("after_rst");
      check("after_rst_state", 32'(dut.state_q), 32'd0);
      check("after_rst_prio",  32'(dut.prio_q),  32'd0);
      next_cycle();
      check("after_rst_gnt0", 32'(m0_gnt),    32'd1);
      check("after_rst_gnt1", 32'(m1_gnt),    32'd0);
      check("after_rst_rv0",  32'(m0_rvalid), 32'd0);
      m0_req = 1'b0; m1_req = 1'b0;
      next_cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
